// File: rtl/booth_r4_mul_if.sv
// ---------------------------------------------------------------------------
// booth_r4_mul_if
//   Request/result bundle between the EX-stage issue logic (master) and the
//   radix-4 Booth multiplier (slave).
//
//   start        master -> slave  request, sampled only while the unit is idle
//   signed_mode  master -> slave  1 = two's-complement operands, 0 = unsigned
//   x            master -> slave  multiplicand, WIDTH bits
//   y            master -> slave  multiplier, WIDTH bits
//   busy         slave -> master  high while an operation is in progress
//   done         slave -> master  one-cycle pulse, z valid while high
//   z            slave -> master  product, 2*WIDTH bits, held until next done
// ---------------------------------------------------------------------------
interface booth_r4_mul_if #(
  parameter int WIDTH = 16
);
  logic                 start;
  logic                 signed_mode;
  logic [WIDTH-1:0]     x;
  logic [WIDTH-1:0]     y;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   z;

  modport master (
    output start, signed_mode, x, y,
    input  busy, done, z
  );

  modport slave (
    input  start, signed_mode, x, y,
    output busy, done, z
  );
endinterface

// File: rtl/booth_r4_mul.sv
// ---------------------------------------------------------------------------
// booth_r4_mul
//   Sequential radix-4 Booth multiplier with configurable operand width and a
//   signed/unsigned mode. Retires two multiplier bits per clock, so an
//   operation takes WIDTH/2+1 cycles; a zero operand short-circuits to a
//   result of 0 one cycle after start.
//
//   clk    rising-edge clock
//   rst_n  synchronous, active-low reset; aborts any operation in flight
//   bus    booth_r4_mul_if.slave: start/signed_mode/x/y in, busy/done/z out
// ---------------------------------------------------------------------------
module booth_r4_mul #(
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  booth_r4_mul_if.slave bus
);

  // Operands get two extra bits so unsigned values stay positive once they
  // are treated as signed Booth operands.
  localparam int W2   = WIDTH + 2;
  localparam int N    = W2 / 2;
  localparam int AW   = W2 + 2;
  localparam int CW   = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CALC = 1'b1;

  generate
    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
      $error("booth_r4_mul: WIDTH must be even and >= 4");
    end
  endgenerate

  logic [0:0]         state;
  logic [CW-1:0]      cnt;
  logic [W2-1:0]      m_reg;
  logic [AW-1:0]      acc;
  logic [W2-1:0]      lo;
  logic [W2:0]        win;
  logic [2*WIDTH-1:0] z_reg;
  logic               done_reg;
  logic               zero_pend;

  logic [W2-1:0]      x_ext;
  logic [W2-1:0]      y_ext;
  logic [AW-1:0]      m_se;
  logic [AW-1:0]      pp;
  logic [AW-1:0]      sum;
  logic [AW-1:0]      acc_nxt;
  logic [W2-1:0]      lo_nxt;
  logic [2*WIDTH-1:0] z_nxt;

  // Operand extension and one Booth step: pick the partial product from the
  // 3-bit window, add it to the upper accumulator, then shift the
  // {acc, lo} pair right by two with sign fill. After N steps the pair holds
  // the full product; only the low 2*WIDTH bits are ever delivered.
  always_comb begin
    x_ext = bus.signed_mode ? {{2{bus.x[WIDTH-1]}}, bus.x} : {2'b00, bus.x};
    y_ext = bus.signed_mode ? {{2{bus.y[WIDTH-1]}}, bus.y} : {2'b00, bus.y};

    m_se = {{2{m_reg[W2-1]}}, m_reg};
    pp   = '0;
    case (win[2:0])
      3'b001, 3'b010: pp = m_se;
      3'b011:         pp = m_se << 1;
      3'b100:         pp = -(m_se << 1);
      3'b101, 3'b110: pp = -m_se;
      default:        pp = '0;
    endcase

    sum     = acc + pp;
    acc_nxt = {{2{sum[AW-1]}}, sum[AW-1:2]};
    lo_nxt  = {sum[1:0], lo[W2-1:2]};
    z_nxt   = (2*WIDTH)'({acc_nxt, lo_nxt});
  end

  // Control and datapath registers. done is a one-cycle pulse raised either
  // by the last Booth step or, one cycle after start, by the zero-operand
  // early-out; the FSM is already IDLE in that cycle, so a new start is
  // accepted without a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      m_reg     <= '0;
      acc       <= '0;
      lo        <= '0;
      win       <= '0;
      z_reg     <= '0;
      done_reg  <= 1'b0;
      zero_pend <= 1'b0;
    end else begin
      done_reg  <= 1'b0;
      zero_pend <= 1'b0;

      if (zero_pend) begin
        z_reg    <= '0;
        done_reg <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            m_reg <= x_ext;
            win   <= {y_ext, 1'b0};
            acc   <= '0;
            lo    <= '0;
            cnt   <= '0;
            if (bus.x == '0 || bus.y == '0) begin
              zero_pend <= 1'b1;
            end else begin
              state <= CALC;
            end
          end
        end

        CALC: begin
          acc <= acc_nxt;
          lo  <= lo_nxt;
          win <= {2'b00, win[W2:2]};
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state    <= IDLE;
            z_reg    <= z_nxt;
            done_reg <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state == CALC);
  assign bus.done = done_reg;
  assign bus.z    = z_reg;

endmodule

// File: tb/tb_booth_r4_mul.sv
// ---------------------------------------------------------------------------
// tb_booth_r4_mul
//   Directed and random checks of booth_r4_mul at WIDTH=16 and WIDTH=8.
//   Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_booth_r4_mul;

  logic clk = 1'b0;
  logic rst_n;

  booth_r4_mul_if #(.WIDTH(16)) bus16 ();
  booth_r4_mul_if #(.WIDTH(8))  bus8 ();

  booth_r4_mul #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  booth_r4_mul #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

  always #5 clk = ~clk;

  int vec_count = 0;
  int err_count = 0;

  task automatic check_output(input string tag, input logic [63:0] obs,
                              input logic [63:0] exp);
    vec_count++;
    assert (obs === exp) else begin
      err_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref16(input logic sm, input logic [15:0] a,
                                        input logic [15:0] b);
    logic [31:0] ea, eb;
    ea = sm ? {{16{a[15]}}, a} : {16'h0, a};
    eb = sm ? {{16{b[15]}}, b} : {16'h0, b};
    return ea * eb;
  endfunction

  function automatic logic [15:0] ref8(input logic sm, input logic [7:0] a,
                                       input logic [7:0] b);
    logic [15:0] ea, eb;
    ea = sm ? {{8{a[7]}}, a} : {8'h0, a};
    eb = sm ? {{8{b[7]}}, b} : {8'h0, b};
    return ea * eb;
  endfunction

  // Issue one start pulse, scramble the inputs right after the start edge,
  // then wait (bounded) for done. lat counts edges after the start edge.
  task automatic apply_stimulus(input logic sm, input logic [15:0] a,
                                input logic [15:0] b,
                                output int lat, output int busy_cnt);
    @(negedge clk);
    bus16.signed_mode = sm;
    bus16.x = a;
    bus16.y = b;
    bus16.start = 1'b1;
    @(negedge clk);
    bus16.start = 1'b0;
    bus16.x = ~a;
    bus16.y = ~b;
    bus16.signed_mode = ~sm;
    lat = 0;
    busy_cnt = 0;
    while (bus16.done !== 1'b1 && lat < 40) begin
      if (bus16.busy === 1'b1) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic apply_stimulus8(input logic sm, input logic [7:0] a,
                                 input logic [7:0] b,
                                 output int lat, output int busy_cnt);
    @(negedge clk);
    bus8.signed_mode = sm;
    bus8.x = a;
    bus8.y = b;
    bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    bus8.x = ~a;
    bus8.y = ~b;
    bus8.signed_mode = ~sm;
    lat = 0;
    busy_cnt = 0;
    while (bus8.done !== 1'b1 && lat < 40) begin
      if (bus8.busy === 1'b1) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_check16(input string tag, input logic sm,
                             input logic [15:0] a, input logic [15:0] b,
                             input logic [31:0] exp_z);
    int lat, busy_cnt;
    logic early;
    early = (a == 16'h0) || (b == 16'h0);
    apply_stimulus(sm, a, b, lat, busy_cnt);
    check_output({tag, ".latency"}, 64'(lat), early ? 64'd1 : 64'd9);
    check_output({tag, ".busy_cycles"}, 64'(busy_cnt), early ? 64'd0 : 64'd9);
    check_output({tag, ".z"}, 64'(bus16.z), 64'(exp_z));
    @(negedge clk);
    check_output({tag, ".done_width"}, 64'(bus16.done), 64'd0);
    check_output({tag, ".z_hold"}, 64'(bus16.z), 64'(exp_z));
  endtask

  task automatic run_check8(input string tag, input logic sm,
                            input logic [7:0] a, input logic [7:0] b,
                            input logic [15:0] exp_z);
    int lat, busy_cnt;
    logic early;
    early = (a == 8'h0) || (b == 8'h0);
    apply_stimulus8(sm, a, b, lat, busy_cnt);
    check_output({tag, ".latency"}, 64'(lat), early ? 64'd1 : 64'd5);
    check_output({tag, ".busy_cycles"}, 64'(busy_cnt), early ? 64'd0 : 64'd5);
    check_output({tag, ".z"}, 64'(bus8.z), 64'(exp_z));
    @(negedge clk);
    check_output({tag, ".done_width"}, 64'(bus8.done), 64'd0);
  endtask

  initial begin
    int lat, dummy;
    logic saw_done;
    logic        sm6 [3];
    logic [15:0] a6  [3];
    logic [15:0] b6  [3];
    logic [31:0] e6  [3];
    logic        rsm;
    logic [15:0] ra, rb;
    logic [7:0]  ra8, rb8;

    rst_n = 1'b0;
    bus16.start = 1'b0; bus16.signed_mode = 1'b0; bus16.x = '0; bus16.y = '0;
    bus8.start  = 1'b0; bus8.signed_mode  = 1'b0; bus8.x  = '0; bus8.y  = '0;
    repeat (2) @(negedge clk);
    check_output("reset.z",    64'(bus16.z),    64'd0);
    check_output("reset.busy", 64'(bus16.busy), 64'd0);
    check_output("reset.done", 64'(bus16.done), 64'd0);
    check_output("reset.z8",   64'(bus8.z),     64'd0);
    rst_n = 1'b1;

    // Most negative squared, all-ones in both modes, -1 * 3, zero early-out
    run_check16("t1_minneg_sq", 1'b1, 16'h8000, 16'h8000, 32'h4000_0000);
    run_check16("t2_uns_ones",  1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
    run_check16("t2_sgn_ones",  1'b1, 16'hFFFF, 16'hFFFF, 32'h0000_0001);
    run_check16("t3_neg1_x3",   1'b1, 16'hFFFF, 16'h0003, 32'hFFFF_FFFD);
    run_check16("t3_zero_y",    1'b1, 16'h1234, 16'h0000, 32'h0000_0000);
    run_check16("t3_zero_x",    1'b0, 16'h0000, 16'hBEEF, 32'h0000_0000);

    // Start re-asserted with new operands while busy must be ignored
    @(negedge clk);
    bus16.signed_mode = 1'b0; bus16.x = 16'h0123; bus16.y = 16'h0456;
    bus16.start = 1'b1;
    @(negedge clk);
    bus16.start = 1'b0;
    lat = 0;
    while (bus16.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 2) begin
        bus16.start = 1'b1; bus16.x = 16'h7777; bus16.y = 16'h1111;
      end
      if (lat == 3) bus16.start = 1'b0;
    end
    check_output("t4_ignore.latency", 64'(lat), 64'd9);
    check_output("t4_ignore.z", 64'(bus16.z), 64'h0004_EDC2);
    @(negedge clk);
    check_output("t4_ignore.idle", 64'(bus16.busy), 64'd0);

    // Reset in the middle of an operation: aborted, no done pulse
    @(negedge clk);
    bus16.signed_mode = 1'b1; bus16.x = 16'h1234; bus16.y = 16'h0002;
    bus16.start = 1'b1;
    @(negedge clk);
    bus16.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_output("t5_reset.busy", 64'(bus16.busy), 64'd0);
    check_output("t5_reset.done", 64'(bus16.done), 64'd0);
    check_output("t5_reset.z",    64'(bus16.z),    64'd0);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus16.done === 1'b1 || bus16.busy === 1'b1) saw_done = 1'b1;
    end
    check_output("t5_reset.no_activity", 64'(saw_done), 64'd0);
    run_check16("t5_after_reset", 1'b1, 16'h0005, 16'hFFFE, 32'hFFFF_FFF6);

    // Start held high, new operands presented in each done cycle: the next
    // operation starts on the edge after done, so dones are N+1 edges apart
    sm6[0] = 1'b0; a6[0] = 16'h0003; b6[0] = 16'h0005; e6[0] = 32'h0000_000F;
    sm6[1] = 1'b0; a6[1] = 16'h00FF; b6[1] = 16'h0100; e6[1] = 32'h0000_FF00;
    sm6[2] = 1'b1; a6[2] = 16'h8000; b6[2] = 16'h0001; e6[2] = 32'hFFFF_8000;
    @(negedge clk);
    bus16.signed_mode = sm6[0]; bus16.x = a6[0]; bus16.y = b6[0];
    bus16.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (bus16.done !== 1'b1 && lat < 40);
      check_output($sformatf("t6_b2b%0d.interval", i), 64'(lat), 64'd10);
      check_output($sformatf("t6_b2b%0d.z", i), 64'(bus16.z), 64'(e6[i]));
      if (i < 2) begin
        bus16.signed_mode = sm6[i+1]; bus16.x = a6[i+1]; bus16.y = b6[i+1];
      end else begin
        bus16.start = 1'b0;
      end
    end
    @(negedge clk);
    check_output("t6_b2b.idle", 64'(bus16.busy), 64'd0);

    // Random operand/mode pairs at WIDTH=16
    for (int i = 0; i < 150; i++) begin
      rsm = 1'($urandom_range(0, 1));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      if (i % 25 == 3) rb = 16'h0;
      if (i % 37 == 5) ra = 16'h8000;
      run_check16($sformatf("rand16_%0d", i), rsm, ra, rb, ref16(rsm, ra, rb));
    end

    // WIDTH=8 corners and random pairs
    run_check8("w8_minneg_sq", 1'b1, 8'h80, 8'h80, 16'h4000);
    run_check8("w8_uns_ones",  1'b0, 8'hFF, 8'hFF, 16'hFE01);
    run_check8("w8_neg1_x3",   1'b1, 8'hFF, 8'h03, 16'hFFFD);
    run_check8("w8_zero",      1'b1, 8'h00, 8'h55, 16'h0000);
    for (int i = 0; i < 100; i++) begin
      rsm = 1'($urandom_range(0, 1));
      ra8 = 8'($urandom);
      rb8 = 8'($urandom);
      run_check8($sformatf("rand8_%0d", i), rsm, ra8, rb8, ref8(rsm, ra8, rb8));
    end

    dummy = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
